// File: rtl/sram_pkg.sv
// Shared types for the asynchronous-SRAM access controller.
// No logic, no latency; holds the FSM encoding and counter sizing.
// No flow control of its own.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        TURN   = 2'd3
    } state_t;

    // Wait and turnaround counters both span 0..15.
    localparam int CNT_W  = $clog2(16);
    localparam int BYTE_W = 8;

    function automatic int lanes(input int dw);
        return dw / BYTE_W;
    endfunction

endpackage

// File: rtl/bidir_pad.sv
// Tristate pad: drives the bus from registered data/enable, returns the bus unregistered.
// Zero latency in both directions; the caller owns every register.
// No backpressure; the enable alone decides who owns the bus.
module bidir_pad #(
    parameter int N = 16
) (
    input  logic [N-1:0] out_dat,
    input  logic         out_en,
    output logic [N-1:0] in_dat,
    inout  wire  [N-1:0] pad
);

    assign pad    = out_en ? out_dat : {N{1'bz}};
    assign in_dat = pad;

endmodule

// File: rtl/sram_bus_ctrl.sv
// Asynchronous-SRAM controller: one req/ready handshake becomes a timed CE/OE/WE/BE cycle with ack.
// Latency: ack in cycle T+3+WAIT_CYC after accept at T; writes add TURN_CYC idle cycles.
// Backpressure: ready only in IDLE; req while not ready is dropped, never queued.
module sram_bus_ctrl
    import sram_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 20,
    parameter int WAIT_CYC = 1,
    parameter int TURN_CYC = 1,
    localparam int NB      = lanes(DW)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req,
    output logic          ready,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [NB-1:0] be,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] SRAM_ADDR,
    inout  wire  [DW-1:0] SRAM_DQ,
    output logic          SRAM_CE_N,
    output logic          SRAM_OE_N,
    output logic          SRAM_WE_N,
    output logic [NB-1:0] SRAM_BE_N
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             dq_oe;
    logic [DW-1:0]    dq_out;
    logic [DW-1:0]    dq_in;

    assign ready = (state == IDLE) && !Reset;

    bidir_pad #(.N(DW)) u_pad (
        .out_dat (dq_out),
        .out_en  (dq_oe),
        .in_dat  (dq_in),
        .pad     (SRAM_DQ)
    );

    // Pin strobes are loaded on the edge before the phase they belong to,
    // so every pin is a flop output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            ack       <= 1'b0;
            rdata     <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_BE_N <= '1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= SETUP;
                        we_q      <= we;
                        SRAM_ADDR <= addr;
                        SRAM_BE_N <= ~be;
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= we;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= we;
                        dq_out    <= wdata;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    cnt       <= '0;
                    SRAM_WE_N <= ~we_q;
                end
                ACCESS: begin
                    if (cnt == WAIT_LAST) begin
                        ack       <= 1'b1;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        SRAM_BE_N <= '1;
                        dq_oe     <= 1'b0;
                        if (!we_q) begin
                            rdata <= dq_in;
                        end
                        // Write turnaround keeps the next access off the bus while it settles.
                        if (we_q && (TURN_CYC > 0)) begin
                            state <= TURN;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TURN: begin
                    if (cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench: two controllers (WAIT_CYC=1 and WAIT_CYC=0) on behavioural SRAMs.
// Checks sample #1 after each rising edge; inputs are driven at the same point.
module tb_sram_bus_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, req, we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        ready, ack;
    logic [15:0] rdata;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
    logic [1:0]  SRAM_BE_N;

    logic        Reset_1, req_1;
    logic        we_1 = 1'b0;
    logic [19:0] addr_1;
    logic [15:0] wdata_1 = 16'h0000;
    logic [1:0]  be_1 = 2'b11;
    logic        ready_1, ack_1;
    logic [15:0] rdata_1;
    logic [19:0] SRAM_ADDR_1;
    wire  [15:0] SRAM_DQ_1;
    logic        SRAM_CE_N_1, SRAM_OE_N_1, SRAM_WE_N_1;
    logic [1:0]  SRAM_BE_N_1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    sram_bus_ctrl #(.DW(16), .AW(20), .WAIT_CYC(1), .TURN_CYC(1)) u0 (
        .Clk(Clk), .Reset(Reset), .req(req), .ready(ready), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ack(ack), .rdata(rdata), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_BE_N(SRAM_BE_N)
    );

    sram_bus_ctrl #(.DW(16), .AW(20), .WAIT_CYC(0), .TURN_CYC(1)) u1 (
        .Clk(Clk), .Reset(Reset_1), .req(req_1), .ready(ready_1), .we(we_1), .addr(addr_1),
        .wdata(wdata_1), .be(be_1), .ack(ack_1), .rdata(rdata_1), .SRAM_ADDR(SRAM_ADDR_1),
        .SRAM_DQ(SRAM_DQ_1), .SRAM_CE_N(SRAM_CE_N_1), .SRAM_OE_N(SRAM_OE_N_1),
        .SRAM_WE_N(SRAM_WE_N_1), .SRAM_BE_N(SRAM_BE_N_1)
    );

    // SRAM for u0: a write commits only after WE_N has been low for two edges,
    // so a truncated write pulse leaves the word untouched.
    logic [15:0] mem [0:255];
    int          we_lo = 0;

    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            we_lo <= we_lo + 1;
            if (we_lo == 1) begin
                if (!SRAM_BE_N[0]) mem[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ[7:0];
                if (!SRAM_BE_N[1]) mem[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ[15:8];
            end
        end else begin
            we_lo <= 0;
        end
    end

    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 16'bz;

    // SRAM for u1: read-only pattern derived from the address.
    assign SRAM_DQ_1 = (!SRAM_CE_N_1 && !SRAM_OE_N_1 && SRAM_WE_N_1) ?
                       (SRAM_ADDR_1[15:0] ^ 16'h5A5A) : 16'bz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [15:0] rd_exp [0:3];

    initial begin
        rd_exp[0] = 16'h5B5A;
        rd_exp[1] = 16'h5B5B;
        rd_exp[2] = 16'h5B58;
        rd_exp[3] = 16'h5B59;

        Reset = 1'b1; req = 1'b1; we = 1'b1; addr = 20'h00077; wdata = 16'h1111; be = 2'b11;
        Reset_1 = 1'b1; req_1 = 1'b0; addr_1 = 20'h00100;

        // Reset held three cycles with req asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", ready, 0);
            chk("rst_ack", ack, 0);
            chk("rst_ce_n", SRAM_CE_N, 1);
            chk("rst_dq_oe", u0.dq_oe, 0);
        end
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_be_n", SRAM_BE_N, 2'b11);
        chk("rst_we_n", SRAM_WE_N, 1);
        chk("rst_oe_n", SRAM_OE_N, 1);
        Reset = 1'b0; req = 1'b0;
        #1;
        chk("post_rst_ready", ready, 1);
        step();
        chk("post_rst_no_access", SRAM_CE_N, 1);
        chk("post_rst_ready2", ready, 1);

        // Full write of 0xBEEF at 0x00012, accepted in cycle T
        req = 1'b1; we = 1'b1; addr = 20'h00012; wdata = 16'hBEEF; be = 2'b11;
        step();  // T+1 SETUP
        req = 1'b0;
        chk("wr_setup_ce_n", SRAM_CE_N, 0);
        chk("wr_setup_we_n", SRAM_WE_N, 1);
        chk("wr_setup_oe_n", SRAM_OE_N, 1);
        chk("wr_setup_dq", SRAM_DQ, 16'hBEEF);
        chk("wr_setup_be_n", SRAM_BE_N, 2'b00);
        chk("wr_setup_addr", SRAM_ADDR, 20'h00012);
        chk("wr_setup_ready", ready, 0);
        step();  // T+2 ACCESS
        chk("wr_acc1_ce_n", SRAM_CE_N, 0);
        chk("wr_acc1_we_n", SRAM_WE_N, 0);
        chk("wr_acc1_dq", SRAM_DQ, 16'hBEEF);
        step();  // T+3 ACCESS
        chk("wr_acc2_we_n", SRAM_WE_N, 0);
        chk("wr_acc2_dq", SRAM_DQ, 16'hBEEF);
        chk("wr_acc2_ack", ack, 0);
        step();  // T+4 TURN, ack
        chk("wr_ack", ack, 1);
        chk("wr_turn_ce_n", SRAM_CE_N, 1);
        chk("wr_turn_we_n", SRAM_WE_N, 1);
        chk("wr_turn_dq_oe", u0.dq_oe, 0);
        chk("wr_turn_ready", ready, 0);
        req = 1'b1; we = 1'b0; addr = 20'h00012;
        step();  // T+5 IDLE, read accepted here
        chk("turn_req_ignored", SRAM_CE_N, 1);
        chk("wr_ack_one_cycle", ack, 0);
        chk("idle_ready", ready, 1);
        step();  // T+6 SETUP
        req = 1'b0;
        chk("rd_setup_ce_n", SRAM_CE_N, 0);
        chk("rd_setup_oe_n", SRAM_OE_N, 0);
        chk("rd_setup_we_n", SRAM_WE_N, 1);
        chk("rd_setup_dq_oe", u0.dq_oe, 0);
        step();  // T+7
        step();  // T+8
        chk("rd_rdata_before", rdata, 0);
        chk("rd_ack_early", ack, 0);
        step();  // T+9 ack
        chk("rd_ack", ack, 1);
        chk("rd_data", rdata, 16'hBEEF);
        chk("rd_ack_oe_n", SRAM_OE_N, 1);
        chk("rd_ack_ready", ready, 1);

        // Upper-byte write of 0x55 over 0xBEEF
        req = 1'b1; we = 1'b1; wdata = 16'h5500; be = 2'b10;
        step();
        req = 1'b0;
        chk("bw_be_n", SRAM_BE_N, 2'b01);
        chk("bw_dq", SRAM_DQ, 16'h5500);
        step();
        chk("bw_acc_we_n", SRAM_WE_N, 0);
        chk("bw_acc_be_n", SRAM_BE_N, 2'b01);
        step();
        step();
        chk("bw_ack", ack, 1);
        step();
        req = 1'b1; we = 1'b0;
        step();
        req = 1'b0;
        step();
        step();
        step();
        chk("bw_rd_ack", ack, 1);
        chk("bw_rd_data", rdata, 16'h55EF);

        // Reset during the first ACCESS cycle of a write
        req = 1'b1; we = 1'b1; wdata = 16'h1234; be = 2'b11;
        step();  // SETUP
        req = 1'b0;
        step();  // first ACCESS
        chk("ab_we_n_low", SRAM_WE_N, 0);
        Reset = 1'b1;
        step();
        chk("ab_we_n", SRAM_WE_N, 1);
        chk("ab_ce_n", SRAM_CE_N, 1);
        chk("ab_dq_oe", u0.dq_oe, 0);
        chk("ab_ack", ack, 0);
        chk("ab_ready", ready, 0);
        chk("ab_rdata", rdata, 0);
        Reset = 1'b0;
        #1;
        step();
        chk("ab_no_late_ack", ack, 0);
        chk("ab_ready_after", ready, 1);
        req = 1'b1; we = 1'b0;
        step();
        req = 1'b0;
        step();
        step();
        step();
        chk("ab_rd_ack", ack, 1);
        chk("ab_mem_unchanged", rdata, 16'h55EF);

        // Back-to-back reads with req held, WAIT_CYC=0
        Reset_1 = 1'b0; req_1 = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("b2b_accept_ready", ready_1, 1);
            step();  // SETUP
            addr_1 = 20'h00100 + 20'(k + 1);
            chk("b2b_setup_ack", ack_1, 0);
            chk("b2b_setup_ce_n", SRAM_CE_N_1, 0);
            chk("b2b_setup_be_n", SRAM_BE_N_1, 2'b00);
            chk("b2b_setup_addr", SRAM_ADDR_1, 20'h00100 + 20'(k));
            chk("b2b_setup_ready", ready_1, 0);
            step();  // ACCESS
            chk("b2b_access_ack", ack_1, 0);
            if (k > 0) chk("b2b_rdata_stable", rdata_1, rd_exp[k-1]);
            step();  // ack, IDLE
            chk("b2b_ack", ack_1, 1);
            chk("b2b_rdata", rdata_1, rd_exp[k]);
            if (k == 3) req_1 = 1'b0;
        end
        step();
        chk("b2b_end_ack", ack_1, 0);
        chk("b2b_end_ready", ready_1, 1);
        chk("b2b_end_rdata", rdata_1, 16'h5B59);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
